// File: rtl/render_sequencer.sv
// render_sequencer: bus master that programs the ray tracer config slave frame by frame,
// double-buffering frames. Optional SEQ_WATCHDOG_EN adds a completion watchdog with flush.
module render_sequencer #(
   parameter int unsigned CONFIG_BASE    = 0,
   parameter int unsigned ADDRESS_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH     = 24,
   parameter int unsigned POSITION_WIDTH = 16,
   parameter int unsigned TIMEOUT_CYCLES = 2**24
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic                               enable,
   input  logic                               normalize,
   input  logic [ADDRESS_WIDTH-1:0]           materialAddress,
   input  logic [ADDRESS_WIDTH-1:0]           treeAddress,
   input  logic [ADDRESS_WIDTH-1:0]           frameAddressA,
   input  logic [ADDRESS_WIDTH-1:0]           frameAddressB,
   input  logic [2:0][POSITION_WIDTH-1:0]     cameraQ,
   input  logic [2:0][POSITION_WIDTH-1:0]     cameraV,
   input  logic [2:0][POSITION_WIDTH-1:0]     cameraX,
   input  logic [2:0][POSITION_WIDTH-1:0]     cameraY,
   input  logic [11:0]                        width,
   input  logic [11:0]                        height,
   input  logic                               interrupt,
   output logic                               msValid,
   input  logic                               msTaken,
   output logic                               msWrite,
   output logic [ADDRESS_WIDTH-1:0]           msAddress,
   output logic [DATA_WIDTH-1:0]              msData,
   output logic [3:0]                         msID,
   input  logic                               smValid,
   output logic                               smTaken,
   output logic [ADDRESS_WIDTH-1:0]           displayAddress,
   output logic                               frameDone,
   output logic [15:0]                        frameCount,
   output logic                               active,
   output logic                               timeoutError
);

   typedef enum logic [2:0] {
      S_IDLE, S_LATCH, S_WRITE, S_START, S_WAIT_DONE, S_SWAP
`ifdef SEQ_WATCHDOG_EN
      , S_FLUSH
`endif
   } state_t;

   localparam logic [4:0] LAST_IDX = 5'h11;

   state_t                    state_q, state_d;
   logic [4:0]                idx_q, idx_d, ms_idx;
   logic                      first_q, first_d, back_q, back_d;
   logic [ADDRESS_WIDTH-1:0]  disp_q, disp_d;
   logic                      disp_init_q;
   logic [15:0]               count_q, count_d;

   logic [ADDRESS_WIDTH-1:8]  mat_q, tree_q;
   logic [ADDRESS_WIDTH-1:0]  frame_a_q, frame_b_q, back_addr;
   logic [POSITION_WIDTH-1:0] cam_q [12];
   logic [11:0]               width_q, height_q;
   logic                      norm_q;
   logic [3:0]                cam_sel;
   logic [DATA_WIDTH-1:0]     reg_data;

`ifdef SEQ_WATCHDOG_EN
   logic [24:0]               wd_q, wd_d;
   logic                      timeout_q, timeout_d;
`endif

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         first_q     <= 1'b1;
         back_q      <= 1'b0;
         disp_q      <= '0;
         disp_init_q <= 1'b1;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         first_q     <= first_d;
         back_q      <= back_d;
         disp_q      <= disp_d;
         disp_init_q <= disp_init_q && (state_q != S_IDLE);
         count_q     <= count_d;
      end
   end

   // NOTE: shadows are pure datapath, always rewritten in LATCH before use, so they carry no reset.
   always_ff @(posedge clock) begin
      if (state_q == S_LATCH) begin
         mat_q     <= materialAddress[ADDRESS_WIDTH-1:8];
         tree_q    <= treeAddress[ADDRESS_WIDTH-1:8];
         frame_a_q <= frameAddressA;
         frame_b_q <= frameAddressB;
         width_q   <= width;
         height_q  <= height;
         norm_q    <= normalize;
         for (int c = 0; c < 3; c++) begin
            cam_q[c]     <= cameraQ[c];
            cam_q[3 + c] <= cameraV[c];
            cam_q[6 + c] <= cameraX[c];
            cam_q[9 + c] <= cameraY[c];
         end
      end
   end

`ifdef SEQ_WATCHDOG_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wd_q      <= '0;
         timeout_q <= 1'b0;
      end else begin
         wd_q      <= wd_d;
         timeout_q <= timeout_d;
      end
   end
   assign timeoutError = timeout_q;
`else
   assign timeoutError = 1'b0;
`endif

   assign back_addr = back_q ? frame_b_q : frame_a_q;
   assign cam_sel   = 4'(idx_q - 5'd4);

   // Register map: 1/2 scene bases, 3 back buffer, 4..F camera Q,V,X,Y, 10/11 resolution.
   always_comb begin
      reg_data = '0;
      case (idx_q) inside
         5'h01:          reg_data = DATA_WIDTH'(mat_q);
         5'h02:          reg_data = DATA_WIDTH'(tree_q);
         5'h03:          reg_data = DATA_WIDTH'(back_addr >> 8);
         [5'h04:5'h0F]:  reg_data = DATA_WIDTH'(cam_q[cam_sel]);
         5'h10:          reg_data = DATA_WIDTH'(width_q);
         5'h11:          reg_data = DATA_WIDTH'(height_q);
         default:        reg_data = '0;
      endcase
   end

   always_comb begin
      // NOTE: every next-state and output gets a default first, so no branch infers a latch.
      state_d   = state_q;
      idx_d     = idx_q;
      first_d   = first_q;
      back_d    = back_q;
      count_d   = count_q;
      disp_d    = disp_q;
      msValid   = 1'b0;
      ms_idx    = 5'd0;
      msData    = '0;
      frameDone = 1'b0;
`ifdef SEQ_WATCHDOG_EN
      wd_d      = wd_q;
      timeout_d = timeout_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (disp_init_q) disp_d = frameAddressB;
            if (enable) state_d = S_LATCH;
         end
         S_LATCH: begin
            idx_d   = first_q ? 5'h01 : 5'h03;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            msValid = 1'b1;
            ms_idx  = idx_q;
            msData  = reg_data;
            if (msTaken) begin
               if (idx_q == LAST_IDX) state_d = S_START;
               else                   idx_d   = idx_q + 5'd1;
            end
         end
         S_START: begin
            msValid = 1'b1;
            msData  = DATA_WIDTH'({norm_q, 4'b0000, 1'b1});
            if (msTaken) begin
               first_d = 1'b0;
               state_d = S_WAIT_DONE;
`ifdef SEQ_WATCHDOG_EN
               wd_d    = '0;
`endif
            end
         end
         S_WAIT_DONE: begin
            if (interrupt) state_d = S_SWAP;
`ifdef SEQ_WATCHDOG_EN
            else if (wd_q == 25'(TIMEOUT_CYCLES - 1)) begin
               timeout_d = 1'b1;
               state_d   = S_FLUSH;
            end else wd_d = wd_q + 25'd1;
`endif
         end
         S_SWAP: begin
            frameDone = 1'b1;
            disp_d    = back_addr;
            back_d    = ~back_q;
            count_d   = count_q + 16'd1;
            state_d   = enable ? S_LATCH : S_IDLE;
         end
`ifdef SEQ_WATCHDOG_EN
         S_FLUSH: begin
            msValid = 1'b1;
            msData  = DATA_WIDTH'(8'h18);
            if (msTaken) begin
               first_d = 1'b1;
               state_d = S_IDLE;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   assign msAddress      = {(ADDRESS_WIDTH-5)'(CONFIG_BASE), ms_idx};
   assign msWrite        = 1'b1;
   assign msID           = 4'd0;
   assign smTaken        = 1'b1;
   assign displayAddress = disp_q;
   assign frameCount     = count_q;
   assign active         = (state_q != S_IDLE);

   logic unused_ok;
`ifdef SEQ_WATCHDOG_EN
   assign unused_ok = ^{smValid, materialAddress[7:0], treeAddress[7:0]};
`else
   assign unused_ok = ^{smValid, materialAddress[7:0], treeAddress[7:0], 32'(TIMEOUT_CYCLES)};
`endif

endmodule
